// File: rtl/ram_read_prefetch_if.sv
// Read-side bus of the sync FIFO: pointer exchange with the write side,
// RAM read port, and the valid/ready output stream.
interface ram_read_prefetch_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int LB_RAM_DEPTH = 8
);
  logic [LB_RAM_DEPTH:0]   wr_ptr;
  logic [LB_RAM_DEPTH:0]   rd_ptr;
  logic                    port_busy;
  logic [LB_RAM_DEPTH-1:0] ram_addr;
  logic                    rd_issue;
  logic [DATA_WIDTH-1:0]   ram_dout;
  logic [DATA_WIDTH-1:0]   dout;
  logic                    dout_valid;
  logic                    dout_ready;

  // Prefetch stage side
  modport master (
    input  wr_ptr, port_busy, ram_dout, dout_ready,
    output rd_ptr, ram_addr, rd_issue, dout, dout_valid
  );

  // Write side, RAM and consumer side
  modport slave (
    output wr_ptr, port_busy, ram_dout, dout_ready,
    input  rd_ptr, ram_addr, rd_issue, dout, dout_valid
  );
endinterface

// File: rtl/ram_read_prefetch.sv
// Read prefetch stage behind a 2-cycle-latency block RAM. Issues reads when
// the port is free and credit allows, tracks them through a 2-stage valid
// pipe and lands returned words in a small circular skid buffer.
module ram_read_prefetch #(
  parameter int DATA_WIDTH   = 8,
  parameter int RAM_DEPTH    = 256,
  parameter int LB_RAM_DEPTH = $clog2(RAM_DEPTH),
  parameter int SKID_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst,
  ram_read_prefetch_if.master bus
);
  localparam int IDX_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CNT_W = $clog2(SKID_DEPTH + 1);
  localparam int CRD_W = CNT_W + 1;

  logic [LB_RAM_DEPTH:0]  rd_ptr;
  logic                   v1;
  logic                   v2;
  logic [DATA_WIDTH-1:0]  mem [SKID_DEPTH];
  logic [IDX_W-1:0]       head;
  logic [IDX_W-1:0]       tail;
  logic [CNT_W-1:0]       count;
  logic                   empty;
  logic                   issue;
  logic                   push;
  logic                   pop;
  logic [CRD_W-1:0]       credit_used;

  function automatic logic [IDX_W-1:0] idx_next(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(SKID_DEPTH - 1)) ? '0 : i + 1'b1;
  endfunction

  // Issue decision: words in flight plus words buffered must leave room
  always_comb begin
    empty       = 1'b0;
    credit_used = '0;
    issue       = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    empty       = (rd_ptr == bus.wr_ptr);
    credit_used = CRD_W'(v1) + CRD_W'(v2) + CRD_W'(count);
    issue       = !rst && !empty && !bus.port_busy &&
                  (credit_used < CRD_W'(SKID_DEPTH));
    push        = v2;
    pop         = (count != '0) && bus.dout_ready;
  end

  assign bus.rd_ptr     = rd_ptr;
  assign bus.ram_addr   = rd_ptr[LB_RAM_DEPTH-1:0];
  assign bus.rd_issue   = issue;
  assign bus.dout_valid = (count != '0);
  assign bus.dout       = (count != '0) ? mem[head] : '0;

  // Read pointer and in-flight valid pipe matching the RAM latency
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      v1     <= 1'b0;
      v2     <= 1'b0;
    end else begin
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      v1 <= issue;
      v2 <= v1;
    end
  end

  // Skid buffer indices and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= idx_next(tail);
      if (pop)  head <= idx_next(head);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Skid buffer storage; contents are don't-care while count is zero
  always_ff @(posedge clk) begin
    if (!rst && push) mem[tail] <= bus.ram_dout;
  end

  // Credit rule guarantees a returning word always has a free slot
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && count == CNT_W'(SKID_DEPTH)));
endmodule

// File: tb/tb_ram_read_prefetch.sv
// Directed bench for ram_read_prefetch with a 2-cycle RAM model and a
// scoreboard of expected output words.
module tb_ram_read_prefetch;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   n_issue;
  int   n_pop;
  logic s_valid;
  logic s_issue;
  logic s_rst;
  logic [8:0] mdl_rd;
  logic [7:0] exp_q [$];
  logic [7:0] ram_mem [256];
  logic [7:0] ram_s1;
  logic [7:0] ram_s2;

  ram_read_prefetch_if #(.DATA_WIDTH(8), .LB_RAM_DEPTH(8)) bus ();

  ram_read_prefetch #(
    .DATA_WIDTH(8), .RAM_DEPTH(256), .LB_RAM_DEPTH(8), .SKID_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: address sampled at an edge, data out two registers later
  always @(posedge clk) begin
    ram_s1 <= ram_mem[bus.ram_addr];
    ram_s2 <= ram_s1;
  end
  assign bus.ram_dout = ram_s2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance wr_ptr, queueing the words that become readable
  task automatic advance_wr(input logic [8:0] new_wr);
    logic [8:0] p;
    p = bus.wr_ptr;
    while (p != new_wr) begin
      exp_q.push_back(ram_mem[p[7:0]]);
      p = p + 1'b1;
    end
    bus.wr_ptr = new_wr;
  endtask

  // One clock cycle: sample mid-cycle, then return just after the next edge
  task automatic cyc();
    @(negedge clk);
    s_valid = bus.dout_valid;
    s_issue = bus.rd_issue;
    s_rst   = rst;
    if (!rst) begin
      chk("rd_ptr", {23'd0, bus.rd_ptr}, {23'd0, mdl_rd});
      if (bus.rd_issue) begin
        chk("ram_addr", {24'd0, bus.ram_addr}, {24'd0, mdl_rd[7:0]});
        mdl_rd = mdl_rd + 1'b1;
        n_issue++;
      end
      if (bus.dout_valid && bus.dout_ready) begin
        if (exp_q.size() == 0) chk("spurious_valid", {31'd0, bus.dout_valid}, 32'd0);
        else chk("dout", {24'd0, bus.dout}, {24'd0, exp_q.pop_front()});
        n_pop++;
      end
    end
    @(posedge clk);
    if (s_rst) begin
      mdl_rd = '0;
      exp_q.delete();
    end
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.wr_ptr     = '0;
    bus.port_busy  = 1'b0;
    bus.dout_ready = 1'b0;
    cyc();
    cyc();
    chk("rst_dout_valid", {31'd0, bus.dout_valid}, 32'd0);
    chk("rst_dout", {24'd0, bus.dout}, 32'd0);
    chk("rst_rd_issue", {31'd0, bus.rd_issue}, 32'd0);
    chk("rst_rd_ptr", {23'd0, bus.rd_ptr}, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_rd_issue", {31'd0, bus.rd_issue}, 32'd0);
    n_issue = 0;
    n_pop   = 0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    mdl_rd   = '0;
    rst      = 1'b1;
    bus.wr_ptr     = '0;
    bus.port_busy  = 1'b0;
    bus.dout_ready = 1'b0;
    for (int i = 0; i < 256; i++) ram_mem[i] = 8'(i) ^ 8'h5A;

    // Single word: valid only in cycle 3
    do_reset();
    ram_mem[0] = 8'hA5;
    bus.dout_ready = 1'b1;
    advance_wr(9'd1);
    for (int c = 0; c < 6; c++) begin
      cyc();
      chk($sformatf("single_valid_c%0d", c), {31'd0, s_valid}, (c == 3) ? 32'd1 : 32'd0);
      chk($sformatf("single_issue_c%0d", c), {31'd0, s_issue}, (c == 0) ? 32'd1 : 32'd0);
    end
    chk("single_rd_ptr", {23'd0, bus.rd_ptr}, 32'd1);
    chk("single_pops", n_pop, 1);

    // Burst of 16 at one word per cycle
    do_reset();
    for (int i = 0; i < 16; i++) ram_mem[i] = 8'(i);
    bus.dout_ready = 1'b1;
    advance_wr(9'd16);
    for (int c = 0; c < 22; c++) begin
      cyc();
      chk($sformatf("burst_valid_c%0d", c), {31'd0, s_valid},
          (c >= 3 && c <= 18) ? 32'd1 : 32'd0);
    end
    chk("burst_rd_ptr", {23'd0, bus.rd_ptr}, 32'd16);
    chk("burst_pops", n_pop, 16);
    chk("burst_q_empty", exp_q.size(), 0);

    // Backpressure: only SKID_DEPTH reads go out while stalled
    do_reset();
    advance_wr(9'd16);
    for (int c = 0; c < 10; c++) cyc();
    chk("bp_issues", n_issue, 4);
    chk("bp_rd_ptr", {23'd0, bus.rd_ptr}, 32'd4);
    chk("bp_valid", {31'd0, bus.dout_valid}, 32'd1);
    chk("bp_dout_held", {24'd0, bus.dout}, 32'd0);
    bus.dout_ready = 1'b1;
    for (int c = 0; c < 24; c++) cyc();
    chk("bp_pops", n_pop, 16);
    chk("bp_issues_total", n_issue, 16);
    chk("bp_q_empty", exp_q.size(), 0);

    // port_busy every other cycle
    do_reset();
    for (int i = 0; i < 16; i++) ram_mem[i] = 8'hC0 + 8'(i);
    bus.dout_ready = 1'b1;
    advance_wr(9'd16);
    for (int c = 0; c < 38; c++) begin
      bus.port_busy = c[0];
      cyc();
      if (c[0]) chk($sformatf("busy_no_issue_c%0d", c), {31'd0, s_issue}, 32'd0);
      chk($sformatf("busy_valid_c%0d", c), {31'd0, s_valid},
          (c >= 3 && c <= 33 && c[0]) ? 32'd1 : 32'd0);
    end
    bus.port_busy = 1'b0;
    chk("busy_pops", n_pop, 16);
    chk("busy_rd_ptr", {23'd0, bus.rd_ptr}, 32'd16);

    // Wrap through the top of the RAM
    do_reset();
    for (int i = 0; i < 256; i++) ram_mem[i] = 8'(i) ^ 8'h5A;
    bus.dout_ready = 1'b1;
    advance_wr(9'd254);
    for (int c = 0; c < 262; c++) cyc();
    chk("wrap_pre_rd_ptr", {23'd0, bus.rd_ptr}, 32'd254);
    advance_wr(9'h102);
    for (int c = 0; c < 10; c++) cyc();
    chk("wrap_rd_ptr", {23'd0, bus.rd_ptr}, 32'h102);
    chk("wrap_msb", {31'd0, bus.rd_ptr[8]}, 32'd1);
    chk("wrap_pops", n_pop, 258);
    chk("wrap_q_empty", exp_q.size(), 0);

    // Reset with two reads in flight
    do_reset();
    bus.dout_ready = 1'b1;
    advance_wr(9'd16);
    cyc();
    cyc();
    chk("mid_issues", n_issue, 2);
    rst = 1'b1;
    bus.wr_ptr = '0;
    cyc();
    rst = 1'b0;
    #1;
    chk("mid_valid", {31'd0, bus.dout_valid}, 32'd0);
    chk("mid_rd_ptr", {23'd0, bus.rd_ptr}, 32'd0);
    chk("mid_issue", {31'd0, bus.rd_issue}, 32'd0);
    for (int c = 0; c < 5; c++) begin
      cyc();
      chk($sformatf("mid_no_valid_c%0d", c), {31'd0, s_valid}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
